// File: rtl/issueq_int_pkg.sv
// rtl/issueq_int_pkg.sv - shared queue widths and entry layout
package issueq_int_pkg;
  localparam int ISSUEQ_INT_DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  localparam int OPC_W = 6;

  // Canonical packed entry image, MSB first; the LS/mult/div queues reuse this layout.
  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] rsdata;
    logic [TAG_W-1:0]  rstag;
    logic              rsvalid;
    logic [DATA_W-1:0] rtdata;
    logic [TAG_W-1:0]  rttag;
    logic              rtvalid;
    logic [TAG_W-1:0]  rdtag;
  } iq_entry_t;
endpackage

// File: rtl/issueq_int_if.sv
// rtl/issueq_int_if.sv - dispatch, CDB and issue signals of the integer issue queue
interface issueq_int_if
  import issueq_int_pkg::*;
#(
  parameter int TAGW  = TAG_W,
  parameter int DATAW = DATA_W
);
  logic             dispatch_int_en;
  logic [OPC_W-1:0] dispatch_opcode;
  logic [DATAW-1:0] dispatch_rsdata;
  logic [TAGW-1:0]  dispatch_rstag;
  logic             dispatch_rsvalid;
  logic [DATAW-1:0] dispatch_rtdata;
  logic [TAGW-1:0]  dispatch_rttag;
  logic             dispatch_rtvalid;
  logic [TAGW-1:0]  dispatch_rdtag;
  logic             issueq_int_full;
  logic             cdb_valid;
  logic [TAGW-1:0]  cdb_tag;
  logic [DATAW-1:0] cdb_data;
  logic             issueint_ready;
  logic [OPC_W-1:0] issueint_opcode;
  logic [DATAW-1:0] issueint_rsdata;
  logic [DATAW-1:0] issueint_rtdata;
  logic [TAGW-1:0]  issueint_rdtag;
  logic             issueint_equeueint_done;

  modport master (
    output dispatch_int_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid, dispatch_rdtag,
           cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
    input  issueq_int_full, issueint_ready, issueint_opcode, issueint_rsdata,
           issueint_rtdata, issueint_rdtag
  );

  modport slave (
    input  dispatch_int_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid, dispatch_rdtag,
           cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
    output issueq_int_full, issueint_ready, issueint_opcode, issueint_rsdata,
           issueint_rtdata, issueint_rdtag
  );
endinterface

// File: rtl/issueq_entry.sv
// rtl/issueq_entry.sv - per-entry CDB tag match and operand capture
module issueq_entry
  import issueq_int_pkg::*;
#(
  parameter int TAGW  = TAG_W,
  parameter int DATAW = DATA_W
) (
  input  logic             valid,
  input  logic [DATAW-1:0] rsdata_in,
  input  logic [TAGW-1:0]  rstag,
  input  logic             rsvalid_in,
  input  logic [DATAW-1:0] rtdata_in,
  input  logic [TAGW-1:0]  rttag,
  input  logic             rtvalid_in,
  input  logic             cdb_valid,
  input  logic [TAGW-1:0]  cdb_tag,
  input  logic [DATAW-1:0] cdb_data,
  output logic [DATAW-1:0] rsdata_out,
  output logic             rsvalid_out,
  output logic [DATAW-1:0] rtdata_out,
  output logic             rtvalid_out
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit      = valid & ~rsvalid_in & cdb_valid & (rstag == cdb_tag);
  assign rt_hit      = valid & ~rtvalid_in & cdb_valid & (rttag == cdb_tag);
  assign rsvalid_out = rsvalid_in | rs_hit;
  assign rtvalid_out = rtvalid_in | rt_hit;
  assign rsdata_out  = rs_hit ? cdb_data : rsdata_in;
  assign rtdata_out  = rt_hit ? cdb_data : rtdata_in;
endmodule

// File: rtl/issueq_int.sv
// rtl/issueq_int.sv - compacting integer issue queue with CDB wakeup and oldest-ready select
module issueq_int
  import issueq_int_pkg::*;
#(
  parameter int DEPTH = ISSUEQ_INT_DEPTH,
  parameter int TAGW  = TAG_W,
  parameter int DATAW = DATA_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  issueq_int_if.slave io
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count;
  logic             q_valid   [DEPTH];
  logic [OPC_W-1:0] q_opcode  [DEPTH];
  logic [DATAW-1:0] q_rsdata  [DEPTH];
  logic [TAGW-1:0]  q_rstag   [DEPTH];
  logic             q_rsvalid [DEPTH];
  logic [DATAW-1:0] q_rtdata  [DEPTH];
  logic [TAGW-1:0]  q_rttag   [DEPTH];
  logic             q_rtvalid [DEPTH];
  logic [TAGW-1:0]  q_rdtag   [DEPTH];

  // Post-shift / post-dispatch image, before wakeup.
  logic             s_valid   [DEPTH];
  logic [OPC_W-1:0] s_opcode  [DEPTH];
  logic [DATAW-1:0] s_rsdata  [DEPTH];
  logic [TAGW-1:0]  s_rstag   [DEPTH];
  logic             s_rsvalid [DEPTH];
  logic [DATAW-1:0] s_rtdata  [DEPTH];
  logic [TAGW-1:0]  s_rttag   [DEPTH];
  logic             s_rtvalid [DEPTH];
  logic [TAGW-1:0]  s_rdtag   [DEPTH];

  logic [DATAW-1:0] w_rsdata  [DEPTH];
  logic             w_rsvalid [DEPTH];
  logic [DATAW-1:0] w_rtdata  [DEPTH];
  logic             w_rtvalid [DEPTH];

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          full;
  logic          issue;
  logic          accept;
  logic [CW-1:0] wr_slot;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q_valid[i] && q_rsvalid[i] && q_rtvalid[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign issue   = sel_found & io.issueint_equeueint_done;
  assign accept  = io.dispatch_int_en & ~full & ~flush;
  assign wr_slot = count - CW'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && i >= int'(sel_idx)) begin
        s_valid[i]   = (i < DEPTH - 1) ? q_valid[(i + 1) % DEPTH] : 1'b0;
        s_opcode[i]  = q_opcode[(i + 1) % DEPTH];
        s_rsdata[i]  = q_rsdata[(i + 1) % DEPTH];
        s_rstag[i]   = q_rstag[(i + 1) % DEPTH];
        s_rsvalid[i] = q_rsvalid[(i + 1) % DEPTH];
        s_rtdata[i]  = q_rtdata[(i + 1) % DEPTH];
        s_rttag[i]   = q_rttag[(i + 1) % DEPTH];
        s_rtvalid[i] = q_rtvalid[(i + 1) % DEPTH];
        s_rdtag[i]   = q_rdtag[(i + 1) % DEPTH];
      end else begin
        s_valid[i]   = q_valid[i];
        s_opcode[i]  = q_opcode[i];
        s_rsdata[i]  = q_rsdata[i];
        s_rstag[i]   = q_rstag[i];
        s_rsvalid[i] = q_rsvalid[i];
        s_rtdata[i]  = q_rtdata[i];
        s_rttag[i]   = q_rttag[i];
        s_rtvalid[i] = q_rtvalid[i];
        s_rdtag[i]   = q_rdtag[i];
      end
      if (accept && CW'(i) == wr_slot) begin
        s_valid[i]   = 1'b1;
        s_opcode[i]  = io.dispatch_opcode;
        s_rsdata[i]  = io.dispatch_rsdata;
        s_rstag[i]   = io.dispatch_rstag;
        s_rsvalid[i] = io.dispatch_rsvalid;
        s_rtdata[i]  = io.dispatch_rtdata;
        s_rttag[i]   = io.dispatch_rttag;
        s_rtvalid[i] = io.dispatch_rtvalid;
        s_rdtag[i]   = io.dispatch_rdtag;
      end
    end
  end

  // Wakeup acts on the post-shift image, so the dispatch slot gets CDB bypass for free.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    issueq_entry #(.TAGW(TAGW), .DATAW(DATAW)) u_ent (
      .valid       (s_valid[g]),
      .rsdata_in   (s_rsdata[g]),
      .rstag       (s_rstag[g]),
      .rsvalid_in  (s_rsvalid[g]),
      .rtdata_in   (s_rtdata[g]),
      .rttag       (s_rttag[g]),
      .rtvalid_in  (s_rtvalid[g]),
      .cdb_valid   (io.cdb_valid),
      .cdb_tag     (io.cdb_tag),
      .cdb_data    (io.cdb_data),
      .rsdata_out  (w_rsdata[g]),
      .rsvalid_out (w_rsvalid[g]),
      .rtdata_out  (w_rtdata[g]),
      .rtvalid_out (w_rtvalid[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_valid[i]   <= 1'b0;
        q_opcode[i]  <= '0;
        q_rsdata[i]  <= '0;
        q_rstag[i]   <= '0;
        q_rsvalid[i] <= 1'b0;
        q_rtdata[i]  <= '0;
        q_rttag[i]   <= '0;
        q_rtvalid[i] <= 1'b0;
        q_rdtag[i]   <= '0;
      end
    end else if (flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q_valid[i] <= 1'b0;
    end else begin
      count <= count - CW'(issue) + CW'(accept);
      for (int i = 0; i < DEPTH; i++) begin
        q_valid[i]   <= s_valid[i];
        q_opcode[i]  <= s_opcode[i];
        q_rsdata[i]  <= w_rsdata[i];
        q_rstag[i]   <= s_rstag[i];
        q_rsvalid[i] <= w_rsvalid[i];
        q_rtdata[i]  <= w_rtdata[i];
        q_rttag[i]   <= s_rttag[i];
        q_rtvalid[i] <= w_rtvalid[i];
        q_rdtag[i]   <= s_rdtag[i];
      end
    end
  end

  assign io.issueq_int_full = full;
  assign io.issueint_ready  = sel_found;
  assign io.issueint_opcode = sel_found ? q_opcode[sel_idx] : '0;
  assign io.issueint_rsdata = sel_found ? q_rsdata[sel_idx] : '0;
  assign io.issueint_rtdata = sel_found ? q_rtdata[sel_idx] : '0;
  assign io.issueint_rdtag  = sel_found ? q_rdtag[sel_idx] : '0;
endmodule

// File: tb/tb_issueq_int.sv
// tb/tb_issueq_int.sv - vector, directed and random checks of issueq_int against a queue model
module tb_issueq_int;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  issueq_int_if #(.TAGW(6), .DATAW(32)) io ();

  issueq_int #(.DEPTH(DEPTH), .TAGW(6), .DATAW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .io    (io)
  );

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] rsd;
    logic [5:0]  rst;
    bit          rsv;
    logic [31:0] rtd;
    logic [5:0]  rtt;
    bit          rtv;
    logic [5:0]  rd;
  } ent_t;

  ent_t mq[$];
  int   msel;

  typedef struct {
    bit en; logic [5:0] opc; logic [31:0] rsd; logic [5:0] rst; bit rsv;
    logic [31:0] rtd; logic [5:0] rtt; bit rtv; logic [5:0] rd;
    bit cv; logic [5:0] ct; logic [31:0] cd; bit done;
    bit e_rdy; logic [5:0] e_opc; logic [31:0] e_rs; logic [31:0] e_rt; logic [5:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit en, logic [5:0] opc, logic [31:0] rsd, logic [5:0] rst, bit rsv,
                              logic [31:0] rtd, logic [5:0] rtt, bit rtv, logic [5:0] rd,
                              bit cv, logic [5:0] ct, logic [31:0] cd, bit done,
                              bit e_rdy, logic [5:0] e_opc, logic [31:0] e_rs, logic [31:0] e_rt,
                              logic [5:0] e_rd);
    vec_t v;
    v.en = en; v.opc = opc; v.rsd = rsd; v.rst = rst; v.rsv = rsv;
    v.rtd = rtd; v.rtt = rtt; v.rtv = rtv; v.rd = rd;
    v.cv = cv; v.ct = ct; v.cd = cd; v.done = done;
    v.e_rdy = e_rdy; v.e_opc = e_opc; v.e_rs = e_rs; v.e_rt = e_rt; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clear_in();
    io.dispatch_int_en = 0; io.dispatch_opcode = 0; io.dispatch_rsdata = 0;
    io.dispatch_rstag = 0; io.dispatch_rsvalid = 0; io.dispatch_rtdata = 0;
    io.dispatch_rttag = 0; io.dispatch_rtvalid = 0; io.dispatch_rdtag = 0;
    io.cdb_valid = 0; io.cdb_tag = 0; io.cdb_data = 0;
    io.issueint_equeueint_done = 0; flush = 0;
  endtask

  task automatic disp(input logic [5:0] opc, input logic [31:0] rsd, input logic [5:0] rst, input bit rsv,
                      input logic [31:0] rtd, input logic [5:0] rtt, input bit rtv, input logic [5:0] rd);
    io.dispatch_int_en = 1; io.dispatch_opcode = opc;
    io.dispatch_rsdata = rsd; io.dispatch_rstag = rst; io.dispatch_rsvalid = rsv;
    io.dispatch_rtdata = rtd; io.dispatch_rttag = rtt; io.dispatch_rtvalid = rtv;
    io.dispatch_rdtag = rd;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    io.cdb_valid = 1; io.cdb_tag = t; io.cdb_data = d;
  endtask

  function automatic int model_sel();
    foreach (mq[i]) if (mq[i].rsv && mq[i].rtv) return i;
    return -1;
  endfunction

  // Called between edges: compares DUT outputs with the oldest ready model entry.
  task automatic check_model();
    msel = model_sel();
    chk("m_ready", 32'(io.issueint_ready), 32'(msel >= 0));
    chk("m_full", 32'(io.issueq_int_full), 32'(mq.size() == DEPTH));
    chk("m_opcode", 32'(io.issueint_opcode), (msel >= 0) ? 32'(mq[msel].opc) : 32'h0);
    chk("m_rsdata", io.issueint_rsdata, (msel >= 0) ? mq[msel].rsd : 32'h0);
    chk("m_rtdata", io.issueint_rtdata, (msel >= 0) ? mq[msel].rtd : 32'h0);
    chk("m_rdtag", 32'(io.issueint_rdtag), (msel >= 0) ? 32'(mq[msel].rd) : 32'h0);
  endtask

  task automatic advance();
    bit   was_full;
    ent_t e;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      if (msel >= 0 && io.issueint_equeueint_done) mq.delete(msel);
      if (io.dispatch_int_en && !was_full) begin
        e.opc = io.dispatch_opcode; e.rsd = io.dispatch_rsdata; e.rst = io.dispatch_rstag;
        e.rsv = io.dispatch_rsvalid; e.rtd = io.dispatch_rtdata; e.rtt = io.dispatch_rttag;
        e.rtv = io.dispatch_rtvalid; e.rd = io.dispatch_rdtag;
        mq.push_back(e);
      end
      if (io.cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].rsv && mq[i].rst == io.cdb_tag) begin mq[i].rsv = 1; mq[i].rsd = io.cdb_data; end
          if (!mq[i].rtv && mq[i].rtt == io.cdb_tag) begin mq[i].rtv = 1; mq[i].rtd = io.cdb_data; end
        end
      end
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    advance();
  endtask

  initial begin
    reset = 0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(io.issueint_ready), 0);
    chk("rst_full", 32'(io.issueq_int_full), 0);
    chk("rst_opcode", 32'(io.issueint_opcode), 0);
    chk("rst_rsdata", io.issueint_rsdata, 0);
    chk("rst_rtdata", io.issueint_rtdata, 0);
    chk("rst_rdtag", 32'(io.issueint_rdtag), 0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;

    vecs.push_back(mk(1, 6'h20, 5, 0, 1, 7, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'h20, 5, 7, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6'h21, 0, 9, 0, 32'h11, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h5555, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h1234, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'h21, 32'h1234, 32'h11, 4));
    vecs.push_back(mk(1, 6'h22, 0, 12, 0, 32'h22, 0, 1, 5, 1, 12, 32'hBEEF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'h22, 32'hBEEF, 32'h22, 5));
    vecs.push_back(mk(1, 6'h23, 0, 7, 0, 0, 7, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hAB, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'h23, 32'hAB, 32'hAB, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      clear_in();
      if (vecs[k].en) disp(vecs[k].opc, vecs[k].rsd, vecs[k].rst, vecs[k].rsv,
                           vecs[k].rtd, vecs[k].rtt, vecs[k].rtv, vecs[k].rd);
      if (vecs[k].cv) cdb(vecs[k].ct, vecs[k].cd);
      io.issueint_equeueint_done = vecs[k].done;
      @(negedge clk);
      chk($sformatf("v%0d_ready", k), 32'(io.issueint_ready), 32'(vecs[k].e_rdy));
      chk($sformatf("v%0d_opcode", k), 32'(io.issueint_opcode), 32'(vecs[k].e_opc));
      chk($sformatf("v%0d_rsdata", k), io.issueint_rsdata, vecs[k].e_rs);
      chk($sformatf("v%0d_rtdata", k), io.issueint_rtdata, vecs[k].e_rt);
      chk($sformatf("v%0d_rdtag", k), 32'(io.issueint_rdtag), 32'(vecs[k].e_rd));
      check_model();
      advance();
    end
    clear_in();

    // Fill with waiting ops, drop the 5th, wake the middle one, then check age order and slot reuse.
    for (int k = 1; k <= 4; k++) begin
      disp(6'(k), 0, 6'(10 + k), 0, 32'h99, 0, 1, 6'(k));
      step();
    end
    clear_in();
    chk("fill_full", 32'(io.issueq_int_full), 1);
    disp(6'h5, 1, 0, 1, 2, 0, 1, 5);
    step();
    clear_in();
    chk("drop5_full", 32'(io.issueq_int_full), 1);
    chk("drop5_ready", 32'(io.issueint_ready), 0);
    cdb(13, 32'h33);
    step();
    clear_in();
    chk("wake_mid_ready", 32'(io.issueint_ready), 1);
    chk("wake_mid_rdtag", 32'(io.issueint_rdtag), 3);
    io.issueint_equeueint_done = 1;
    step();
    clear_in();
    chk("issue_frees_full", 32'(io.issueq_int_full), 0);
    disp(6'h7, 32'h70, 0, 1, 32'h71, 0, 1, 7);
    cdb(14, 32'h44);
    step();
    clear_in();
    chk("age_order_rdtag", 32'(io.issueint_rdtag), 4);
    io.issueint_equeueint_done = 1;
    step();
    chk("slot3_rdtag", 32'(io.issueint_rdtag), 7);
    step();
    clear_in();
    chk("drained_ready", 32'(io.issueint_ready), 0);
    cdb(11, 32'h11); step();
    cdb(12, 32'h12); step();
    clear_in();
    chk("order_first_rdtag", 32'(io.issueint_rdtag), 1);
    io.issueint_equeueint_done = 1;
    step();
    chk("order_second_rdtag", 32'(io.issueint_rdtag), 2);
    step();
    clear_in();
    chk("empty_ready", 32'(io.issueint_ready), 0);

    // Full queue: issue and dispatch in one cycle must drop the dispatch.
    for (int k = 1; k <= 4; k++) begin
      disp(6'(k), 32'(k), 20, (k == 1), 32'h5, 0, 1, 6'(k));
      step();
    end
    clear_in();
    chk("dual_pre_full", 32'(io.issueq_int_full), 1);
    io.issueint_equeueint_done = 1;
    disp(6'h9, 1, 0, 1, 1, 0, 1, 9);
    step();
    clear_in();
    chk("dual_ready", 32'(io.issueint_ready), 0);
    chk("dual_full", 32'(io.issueq_int_full), 0);
    disp(6'ha, 1, 0, 1, 1, 0, 1, 10);
    step();
    clear_in();
    chk("dual_refill_full", 32'(io.issueq_int_full), 1);
    chk("dual_refill_rdtag", 32'(io.issueint_rdtag), 10);
    io.issueint_equeueint_done = 1;
    step();
    clear_in();

    // Flush with a concurrent dispatch, then async reset away from any clock edge.
    flush = 1;
    disp(6'hb, 1, 0, 1, 1, 0, 1, 11);
    step();
    clear_in();
    chk("flush_ready", 32'(io.issueint_ready), 0);
    chk("flush_full", 32'(io.issueq_int_full), 0);
    disp(6'h8, 32'h80, 0, 1, 32'h81, 0, 1, 8);
    step();
    clear_in();
    chk("post_flush_rdtag", 32'(io.issueint_rdtag), 8);
    #2;
    reset = 0;
    #1;
    chk("async_rst_ready", 32'(io.issueint_ready), 0);
    chk("async_rst_rdtag", 32'(io.issueint_rdtag), 0);
    chk("async_rst_rsdata", io.issueint_rsdata, 0);
    mq.delete();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;

    for (int c = 0; c < 1500; c++) begin
      clear_in();
      if ($urandom_range(0, 1) == 1)
        disp(6'($urandom), $urandom, 6'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
             $urandom, 6'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), 6'($urandom));
      if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 7)), $urandom);
      io.issueint_equeueint_done = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/issueq_int.md
Name: issueq_int

Overview:
- Integer issue queue directly upstream of the issue/CDB-arbitration stage.
- Buffers dispatched integer/branch ops until both source operands are available. Operands are captured from dispatch or by snooping the CDB (wakeup).
- Each cycle it presents the oldest ready op on the issueint_* interface. The op is removed when the issue stage asserts issueint_equeueint_done.

Parameters:
- DEPTH, 4, number of queue entries (≥2).
- TAGW, 6, physical/ROB tag width.
- DATAW, 32, operand data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries (branch mispredict).
- dispatch_int_en  in  1  write one op this cycle.
- dispatch_opcode  in  6  ALU/branch opcode.
- dispatch_rsdata  in  DATAW  rs value, meaningful if dispatch_rsvalid.
- dispatch_rstag  in  TAGW  rs producer tag if not valid.
- dispatch_rsvalid  in  1  rs value present.
- dispatch_rtdata, dispatch_rttag, dispatch_rtvalid  in  DATAW/TAGW/1  same for rt.
- dispatch_rdtag  in  TAGW  destination tag.
- issueq_int_full  out  1  no free entry; dispatch refused.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAGW  broadcast tag.
- cdb_data  in  DATAW  broadcast value.
- issueint_ready  out  1  selected entry presented.
- issueint_opcode  out  6  selected opcode.
- issueint_rsdata  out  DATAW  selected rs value.
- issueint_rtdata  out  DATAW  selected rt value.
- issueint_rdtag  out  TAGW  selected destination tag.
- issueint_equeueint_done  in  1  issue stage accepted the presented op this cycle.

Behaviour:
- Storage: DEPTH entries in age order (entry 0 oldest), compacting/shifting. Each entry holds valid, opcode, rs{data,tag,valid}, rt{data,tag,valid}, rdtag. count register is $clog2(DEPTH+1) bits.
- Reset (reset=0, async):
  - All entry valids and count = 0.
  - issueint_ready=0, issueq_int_full=0. Other outputs 0, because they are driven as 0 when not ready.
- Full: issueq_int_full = (count==DEPTH), registered-count based only. A same-cycle issue does NOT free a slot for dispatch.
- Dispatch accepted iff dispatch_int_en & ~issueq_int_full & ~flush. Dispatch while full or during flush is silently dropped.
- Select (combinational): the lowest-index entry with valid & rsvalid & rtvalid.
  - issueint_ready=1 and outputs carry that entry.
  - With no ready entry: ready=0 and data/tag/opcode outputs = 0.
  - Wakeup is not forwarded combinationally to select. An operand woken at edge N makes its entry selectable from cycle N+1.
- Issue: at the clock edge where issueint_ready & issueint_equeueint_done, the selected entry is removed. Older entries stay put; younger entries shift down one slot. done while ready=0 is ignored.
- Dispatch write: the new op goes to slot (count − removed), i.e. after compaction. Simultaneous issue + dispatch leaves count unchanged.
- Wakeup: on each edge with cdb_valid, every valid entry with rsvalid=0 and rstag==cdb_tag captures cdb_data and sets rsvalid. Same rule for rt. This applies to shifted entries as well, since the update is applied to the post-shift image.
- Dispatch bypass: if a dispatched operand has valid=0 and its tag matches the same-cycle cdb_tag with cdb_valid, it is stored as valid with cdb_data.
- Same tag on rs and rt: both operands wake.
- Flush: synchronous. At the edge it clears all valids and count, and has priority over dispatch, issue and wakeup. Outputs are not gated by flush in the flush cycle itself (the issue stage may still consume).
- Reset asserted mid-operation clears everything immediately. No partial state survives.
- Opcode is carried opaquely; no decode in this block.
- Latency: dispatch with both operands valid at edge N → issueint_ready from cycle N+1 (if oldest ready).

Decomposition:
- Shared package globals.vh gains:
  - ISSUEQ_INT_DEPTH
  - TAG_W
  - DATA_W
  - the entry field layout (struct-like bit offsets) for reuse by the LS/mult/div queues.
- One sub-module: issueq_entry. It holds a single entry's operand-capture/wakeup logic: tag compare and data mux for rs and rt. It is instantiated DEPTH times; the top module holds shift, select and count.

Test Plan:
- Reset then dispatch op opcode=0x20, rs=5, rt=7, both valid, rdtag=3 → next cycle ready=1, rsdata=5, rtdata=7, rdtag=3. Assert done → ready=0 the cycle after, count=0.
- Dispatch rs waiting on tag 9 (rt valid = 1). Hold done=0. Broadcast cdb_valid=1, tag=9, data=0x1234 → next cycle ready=1, rsdata=0x1234. CDB tag 8 instead → ready stays 0.
- Fill 4 entries (rdtags 1..4), none ready → full=1. A 5th dispatch is dropped. Wake entry 2 (rdtag 3) → issued first. After done: full=0, order preserved as 1,2,4; the next dispatch lands in slot 3.
- Full queue, entry 0 ready, done and dispatch in the same cycle → dispatch dropped, count=3.
- Dispatch with rstag=12 invalid while cdb_valid=1, tag=12, data=0xBEEF → stored valid; ready next cycle with rsdata=0xBEEF.
- Three entries queued, then flush=1 together with dispatch_int_en=1 → next cycle count=0, ready=0, full=0. Assert reset low mid-stream → outputs 0 immediately, without waiting for clk.
